st2bus_pkt: RTL and testbench
=============================

Name: st2bus_pkt

Overview:
- Single-clock, parametrised successor to the fixed-1024 ST-to-bus packer.
- Accepts variable-length Avalon-ST packets (sop..eop) of ST-bit symbols from the turbo decoder output and packs them into ST_PER_BUS-bit bus words.
- Buffers packed words in an internal FIFO and drains them to the bus under bus_ready flow control.
- Each output word is marked with an end-of-packet flag and a valid-symbol count. A programmable idle gap is enforced on the bus after every packet.

Parameters:
- ST, 8, symbol width in bits.
- ST_PER_BUS, 512, bus word width in bits; must be a multiple of ST.
- NUM_ST_PER_BUS, 64, symbols per bus word; must equal ST_PER_BUS/ST.
- FIFO_DEPTH, 8, packed-word FIFO entries; power of two, >=2.
- GAP_CYCLES, 25, minimum idle clk_bus cycles after an eop word before the next bus_en; 0 disables the gap.
- NSYM_W, 7, width of the symbol count; equals clog2(NUM_ST_PER_BUS+1).

Ports:
- clk_bus  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- st_data  in  ST  input symbol.
- st_valid  in  1  symbol valid.
- st_sop  in  1  first symbol of packet.
- st_eop  in  1  last symbol of packet.
- st_ready  out  1  block can accept a symbol this cycle.
- bus_ready  in  1  downstream permits a pop this cycle.
- bus_data  out  ST_PER_BUS  packed word.
- bus_en  out  1  bus_data/bus_eop/bus_nsym valid (one-cycle qualifier).
- bus_eop  out  1  word is the last of its packet.
- bus_nsym  out  NSYM_W  valid symbols in word, 1..NUM_ST_PER_BUS.
- err_pulse  out  1  one-cycle protocol-error flag.

Behaviour:
- Reset (async assert, sync release): all outputs 0 (st_ready 0 while rst_n low), FIFO empty, both FSMs idle, pack register and symbol index cleared.
- Accept: a beat is accepted when st_valid && st_ready.
- st_ready: st_ready = (fifo_count < FIFO_DEPTH), computed from the registered count only, with no combinational path from bus_ready.
- Input FSM, IDLE: an accepted beat with st_sop enters IN_PKT. sop with eop is a 1-symbol packet and stays in IDLE. An accepted beat without sop is dropped and raises err_pulse.
- Input FSM, IN_PKT: each accepted beat writes st_data to pack bits [ST*idx+ST-1 : ST*idx], so symbol 0 of each word sits in the LSBs. idx then increments.
- Word completion: when idx==NUM_ST_PER_BUS-1 or st_eop, the completed word (including the current symbol) is pushed to the FIFO on the same edge. Unwritten bits are 0, nsym=idx+1, eop=st_eop. idx and pack clear. eop returns the FSM to IDLE.
- sop in IN_PKT: the partial word is discarded, err_pulse is raised, and the new packet starts with this symbol at idx 0.
- FIFO entry: {eop, nsym, data}. A push and a pop in the same cycle leave the count unchanged.
- Output FSM, SEND: if FIFO non-empty and bus_ready, pop the head. On the next edge drive bus_data/bus_eop/bus_nsym from it and set bus_en=1. Otherwise bus_en=0 and bus_data holds its last value.
- Output FSM, SEND to GAP: popping an eop word moves to GAP when GAP_CYCLES>0.
- Output FSM, GAP: no pops for GAP_CYCLES cycles, counted from the cycle after the eop word's bus_en; then return to SEND. bus_ready is ignored in GAP.
- Latency: last symbol of a word accepted at edge N gives the FIFO entry at N; earliest bus_en is at N+2.
- Throughput: one word per cycle when bus_ready is held high.
- Full FIFO: st_ready=0; st_data and flags are ignored and no beat is lost. st_ready rises one cycle after the pop that frees a slot.
- Reset mid-packet: the partial word and FIFO contents are discarded, and no bus_en occurs after reset release until new input arrives.

Test Plan:
- 128-symbol packet, symbol k = k[7:0], bus_ready=1 -> 2 words. Word0 byte i = i, word1 byte i = 64+i; nsym 64/64; bus_eop 0 then 1; first bus_en 2 cycles after the 64th accept.
- 70-symbol packet -> word1 has nsym=6, bits[47:0] = 64..69, bits[511:48]=0, bus_eop=1.
- 1-symbol packet (sop=eop=1, data 8'hA5) -> one word with nsym=1, bits[7:0]=A5, rest 0, eop=1.
- bus_ready=0, 640-symbol packet -> 8 words buffered, st_ready=0 after the 512th symbol. Release bus_ready: all 10 words in order, no symbol lost or duplicated.
- Two back-to-back 128-symbol packets, GAP_CYCLES=25 -> exactly 25 cycles of bus_en=0 between packet 1's eop word and packet 2's first word.
- sop at symbol 30 of a packet -> err_pulse for 1 cycle, first 30 symbols dropped. Valid without sop in IDLE -> err_pulse, no push. rst_n low at symbol 100 -> outputs 0 and no stray bus_en after release.

Source files
------------

// File: rtl/st2bus_pkt.sv
// -----------------------------------------------------------------------------
// st2bus_pkt
//
// Packs variable-length Avalon-ST packets of ST-bit symbols into ST_PER_BUS-bit
// bus words, buffers them in a small FIFO and drains them to the bus under
// bus_ready flow control. Each bus word carries an end-of-packet flag and a
// count of valid symbols. After the last word of a packet, the bus is held
// idle for GAP_CYCLES cycles before the next word is sent.
//
// Ports:
//   clk_bus    in   single clock for the whole block
//   rst_n      in   asynchronous active-low reset
//   st_data    in   input symbol (ST bits)
//   st_valid   in   symbol valid
//   st_sop     in   first symbol of packet
//   st_eop     in   last symbol of packet
//   st_ready   out  block can accept a symbol this cycle
//   bus_ready  in   downstream permits a pop this cycle
//   bus_data   out  packed word (symbol 0 in the LSBs)
//   bus_en     out  one-cycle qualifier for bus_data/bus_eop/bus_nsym
//   bus_eop    out  word is the last of its packet
//   bus_nsym   out  valid symbols in word, 1..NUM_ST_PER_BUS
//   err_pulse  out  one-cycle protocol-error flag
// -----------------------------------------------------------------------------
module st2bus_pkt #(
    parameter int unsigned ST             = 8,
    parameter int unsigned ST_PER_BUS     = 512,
    parameter int unsigned NUM_ST_PER_BUS = 64,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned GAP_CYCLES     = 25,
    parameter int unsigned NSYM_W         = 7
) (
    input  logic                  clk_bus,
    input  logic                  rst_n,
    input  logic [ST-1:0]         st_data,
    input  logic                  st_valid,
    input  logic                  st_sop,
    input  logic                  st_eop,
    output logic                  st_ready,
    input  logic                  bus_ready,
    output logic [ST_PER_BUS-1:0] bus_data,
    output logic                  bus_en,
    output logic                  bus_eop,
    output logic [NSYM_W-1:0]     bus_nsym,
    output logic                  err_pulse
);

    localparam int unsigned IDX_W = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 1 + NSYM_W + ST_PER_BUS;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ST_PER_BUS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic {InIdle, InPkt} in_state_e;
    typedef enum logic {OutSend, OutGap} out_state_e;

    // ------------------------------------------------------------------------
    // Input side: packet FSM and word packer
    // ------------------------------------------------------------------------
    in_state_e             in_state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [ST_PER_BUS-1:0] pack_q;
    logic                  err_q;
    logic                  st_ready_q;

    logic                  accept;
    logic                  take;
    logic                  word_done;
    logic [IDX_W-1:0]      widx;
    logic [ST_PER_BUS-1:0] pack_w;
    logic [NSYM_W-1:0]     nsym_w;
    logic [ENT_W-1:0]      push_entry;
    logic                  push;

    assign accept = st_valid & st_ready_q;

    // A beat is kept if it opens a packet or continues one; a beat without
    // sop outside a packet is dropped.
    assign take = accept & (st_sop | (in_state_q == InPkt));

    // sop always restarts the word at symbol 0, discarding any partial word.
    assign widx = st_sop ? '0 : idx_q;

    assign word_done  = take & (st_eop | (widx == LAST_IDX));
    assign push       = word_done;
    assign nsym_w     = NSYM_W'(widx) + NSYM_W'(1);
    assign push_entry = {st_eop, nsym_w, pack_w};

    always_comb begin
        pack_w = st_sop ? '0 : pack_q;
        pack_w[widx * ST +: ST] = st_data;
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            in_state_q <= InIdle;
            idx_q      <= '0;
            pack_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            // Error: sop inside a packet, or a non-sop beat while idle.
            err_q <= accept & (st_sop ? (in_state_q == InPkt) : (in_state_q == InIdle));
            if (take) begin
                if (word_done) begin
                    idx_q      <= '0;
                    pack_q     <= '0;
                    in_state_q <= st_eop ? InIdle : InPkt;
                end else begin
                    idx_q      <= widx + IDX_W'(1);
                    pack_q     <= pack_w;
                    in_state_q <= InPkt;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Packed-word FIFO: entry = {eop, nsym, data}
    // ------------------------------------------------------------------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [ENT_W-1:0] head;
    logic             pop;

    out_state_e       out_state_q;

    assign head = mem[rd_ptr_q];
    assign pop  = (out_state_q == OutSend) & (count_q != '0) & bus_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_bus) begin
        if (push) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            st_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            // Registered so st_ready has no combinational path from bus_ready.
            st_ready_q <= (count_d < DEPTH_C);
        end
    end

    // ------------------------------------------------------------------------
    // Output side: send/gap FSM, read stage and bus registers
    // ------------------------------------------------------------------------
    logic [GAP_W-1:0]      gap_q;
    logic                  rd_valid_q;
    logic [ENT_W-1:0]      rd_entry_q;
    logic                  bus_en_q;
    logic                  bus_eop_q;
    logic [NSYM_W-1:0]     bus_nsym_q;
    logic [ST_PER_BUS-1:0] bus_data_q;

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q <= OutSend;
            gap_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_entry_q  <= '0;
            bus_en_q    <= 1'b0;
            bus_eop_q   <= 1'b0;
            bus_nsym_q  <= '0;
            bus_data_q  <= '0;
        end else begin
            // Popped entry is staged for one cycle before reaching the bus.
            rd_valid_q <= pop;
            if (pop) begin
                rd_entry_q <= head;
            end

            bus_en_q <= rd_valid_q;
            if (rd_valid_q) begin
                {bus_eop_q, bus_nsym_q, bus_data_q} <= rd_entry_q;
            end

            unique case (out_state_q)
                OutSend: begin
                    if (pop && head[ENT_W-1] && (GAP_CYCLES > 0)) begin
                        out_state_q <= OutGap;
                        gap_q       <= GAP_LOAD;
                    end
                end
                OutGap: begin
                    // Last gap cycle releases SEND so the next pop lands
                    // exactly GAP_CYCLES idle bus cycles after the eop word.
                    if (gap_q == '0) begin
                        out_state_q <= OutSend;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: out_state_q <= OutSend;
            endcase
        end
    end

    assign st_ready  = st_ready_q;
    assign bus_en    = bus_en_q;
    assign bus_eop   = bus_eop_q;
    assign bus_nsym  = bus_nsym_q;
    assign bus_data  = bus_data_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_st2bus_pkt.sv
module tb_st2bus_pkt;

    localparam int ST    = 8;
    localparam int SPB   = 512;
    localparam int NPB   = 64;
    localparam int DEPTH = 8;
    localparam int GAP   = 25;
    localparam int NSW   = 7;

    logic           clk_bus = 1'b0;
    logic           rst_n;
    logic [ST-1:0]  st_data;
    logic           st_valid;
    logic           st_sop;
    logic           st_eop;
    logic           st_ready;
    logic           bus_ready;
    logic [SPB-1:0] bus_data;
    logic           bus_en;
    logic           bus_eop;
    logic [NSW-1:0] bus_nsym;
    logic           err_pulse;

    always #5 clk_bus = ~clk_bus;

    st2bus_pkt #(
        .ST             (ST),
        .ST_PER_BUS     (SPB),
        .NUM_ST_PER_BUS (NPB),
        .FIFO_DEPTH     (DEPTH),
        .GAP_CYCLES     (GAP),
        .NSYM_W         (NSW)
    ) dut (
        .clk_bus   (clk_bus),
        .rst_n     (rst_n),
        .st_data   (st_data),
        .st_valid  (st_valid),
        .st_sop    (st_sop),
        .st_eop    (st_eop),
        .st_ready  (st_ready),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .bus_en    (bus_en),
        .bus_eop   (bus_eop),
        .bus_nsym  (bus_nsym),
        .err_pulse (err_pulse)
    );

    typedef struct {
        logic [SPB-1:0] data;
        logic           eop;
        logic [NSW-1:0] nsym;
        int             cyc;
    } word_t;

    word_t exp_q[$];
    word_t obs_q[$];

    int tests   = 0;
    int fails   = 0;
    int cyc     = 0;
    int acc_n   = 0;
    int acc63   = 0;
    int err_n   = 0;
    int br_mode = 0;   // 0: bus_ready high, 1: low, 2: random
    bit stuck   = 0;

    always @(posedge clk_bus) cyc <= cyc + 1;

    // Bus-side driver and monitor, both on the falling edge.
    always @(negedge clk_bus) begin
        word_t w;
        case (br_mode)
            0:       bus_ready = 1'b1;
            1:       bus_ready = 1'b0;
            default: bus_ready = 1'($urandom_range(0, 1));
        endcase
        if (rst_n && bus_en) begin
            w.data = bus_data;
            w.eop  = bus_eop;
            w.nsym = bus_nsym;
            w.cyc  = cyc;
            obs_q.push_back(w);
        end
        if (rst_n && err_pulse) err_n++;
    end

    // Packet-level reference: chop the symbol list into NPB-symbol words.
    task automatic model_pkt(input logic [7:0] syms[$]);
        int n;
        n = syms.size();
        for (int base = 0; base < n; base += NPB) begin
            word_t e;
            int    cnt;
            cnt    = (n - base > NPB) ? NPB : n - base;
            e.data = '0;
            for (int i = 0; i < cnt; i++) e.data[i*8 +: 8] = syms[base+i];
            e.nsym = NSW'(cnt);
            e.eop  = (base + cnt == n);
            e.cyc  = 0;
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive_beat(input logic [7:0] d, input logic sop, input logic eop,
                              output int acc_cyc);
        int t;
        st_data  = d;
        st_sop   = sop;
        st_eop   = eop;
        st_valid = 1'b1;
        t = stuck ? 2000 : 0;
        while (!st_ready && t < 2000) begin
            @(negedge clk_bus);
            t++;
        end
        if (t >= 2000 && !stuck) begin
            stuck = 1;
            tests++;
            fails++;
            $display("FAIL beat_timeout: st_ready=%b, required 1 within 2000 cycles", st_ready);
        end
        @(negedge clk_bus);
        acc_n++;
        acc_cyc = cyc;
    endtask

    task automatic send_pkt(input int len, input bit rand_data, input int max_gap,
                            input int sop_at);
        logic [7:0] syms[$];
        logic [7:0] d;
        int         a;
        int         g;
        for (int k = 0; k < len; k++) begin
            if (max_gap > 0) begin
                g = $urandom_range(0, max_gap);
                if (g > 0) begin
                    st_valid = 1'b0;
                    repeat (g) @(negedge clk_bus);
                end
            end
            d = rand_data ? 8'($urandom) : 8'(k);
            drive_beat(d, (k == 0) || (k == sop_at), k == len - 1, a);
            if (k == 63) acc63 = a;
            if (k >= sop_at) syms.push_back(d);
        end
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        model_pkt(syms);
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && obs_q.size() < exp_q.size(); t++) @(negedge clk_bus);
        repeat (40) @(negedge clk_bus);
    endtask

    task automatic clear();
        exp_q.delete();
        obs_q.delete();
        err_n = 0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        st_data  = '0;
        bus_ready = 1'b0;
        br_mode  = 0;
        repeat (3) @(negedge clk_bus);
        tests++;
        if (st_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_st_ready: got %b, want 0", st_ready);
        end
        tests++;
        if ({bus_en, bus_eop, bus_nsym, bus_data, err_pulse} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b eop=%b nsym=%0d err=%b data!=0:%b, want all 0",
                     bus_en, bus_eop, bus_nsym, err_pulse, |bus_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk_bus);
        tests++;
        if (st_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, want 1", st_ready);
        end
    endtask

    task automatic test_p128();
        clear();
        br_mode = 0;
        send_pkt(128, 0, 0, -1);
        drain();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL p128_count: got %0d words, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if ({obs_q[i].eop, obs_q[i].nsym, obs_q[i].data} !==
                {exp_q[i].eop, exp_q[i].nsym, exp_q[i].data}) begin
                fails++;
                $display("FAIL p128_word%0d: got eop=%b nsym=%0d data=%h, want eop=%b nsym=%0d data=%h",
                         i, obs_q[i].eop, obs_q[i].nsym, obs_q[i].data,
                         exp_q[i].eop, exp_q[i].nsym, exp_q[i].data);
            end
        end
        if (obs_q.size() > 0) begin
            tests++;
            if (obs_q[0].cyc !== acc63 + 2) begin
                fails++;
                $display("FAIL p128_latency: first bus_en at cycle %0d, want %0d",
                         obs_q[0].cyc, acc63 + 2);
            end
        end
        tests++;
        if (err_n !== 0) begin
            fails++;
            $display("FAIL p128_err: got %0d err pulses, want 0", err_n);
        end
    endtask

    task automatic test_short();
        logic [7:0] one[$];
        int         a;
        clear();
        br_mode = 0;
        send_pkt(70, 0, 0, -1);
        @(negedge clk_bus);
        drive_beat(8'hA5, 1'b1, 1'b1, a);
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        one.push_back(8'hA5);
        model_pkt(one);
        drain();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL short_count: got %0d words, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if ({obs_q[i].eop, obs_q[i].nsym, obs_q[i].data} !==
                {exp_q[i].eop, exp_q[i].nsym, exp_q[i].data}) begin
                fails++;
                $display("FAIL short_word%0d: got eop=%b nsym=%0d data=%h, want eop=%b nsym=%0d data=%h",
                         i, obs_q[i].eop, obs_q[i].nsym, obs_q[i].data,
                         exp_q[i].eop, exp_q[i].nsym, exp_q[i].data);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        clear();
        br_mode = 1;
        base    = acc_n;
        fork
            send_pkt(640, 0, 0, -1);
            begin
                for (int t = 0; t < 5000 && acc_n < base + 512; t++) @(negedge clk_bus);
                repeat (4) @(negedge clk_bus);
                tests++;
                if (st_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_full_ready: got %b, want 0", st_ready);
                end
                tests++;
                if (acc_n - base !== 512) begin
                    fails++;
                    $display("FAIL bp_accepted: got %0d symbols, want 512", acc_n - base);
                end
                br_mode = 0;
            end
        join
        drain();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL bp_count: got %0d words, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if ({obs_q[i].eop, obs_q[i].nsym, obs_q[i].data} !==
                {exp_q[i].eop, exp_q[i].nsym, exp_q[i].data}) begin
                fails++;
                $display("FAIL bp_word%0d: got eop=%b nsym=%0d data=%h, want eop=%b nsym=%0d data=%h",
                         i, obs_q[i].eop, obs_q[i].nsym, obs_q[i].data,
                         exp_q[i].eop, exp_q[i].nsym, exp_q[i].data);
            end
        end
        if (obs_q.size() >= 8) begin
            tests++;
            if (obs_q[7].cyc - obs_q[0].cyc !== 7) begin
                fails++;
                $display("FAIL bp_throughput: 8 buffered words span %0d cycles, want 7",
                         obs_q[7].cyc - obs_q[0].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear();
        br_mode = 1;
        send_pkt(128, 1, 0, -1);
        @(negedge clk_bus);
        send_pkt(128, 1, 0, -1);
        br_mode = 0;
        drain();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL b2b_count: got %0d words, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if ({obs_q[i].eop, obs_q[i].nsym, obs_q[i].data} !==
                {exp_q[i].eop, exp_q[i].nsym, exp_q[i].data}) begin
                fails++;
                $display("FAIL b2b_word%0d: got eop=%b nsym=%0d data=%h, want eop=%b nsym=%0d data=%h",
                         i, obs_q[i].eop, obs_q[i].nsym, obs_q[i].data,
                         exp_q[i].eop, exp_q[i].nsym, exp_q[i].data);
            end
        end
        if (obs_q.size() >= 3) begin
            tests++;
            if (obs_q[2].cyc - obs_q[1].cyc - 1 !== GAP) begin
                fails++;
                $display("FAIL b2b_gap: got %0d idle cycles, want %0d",
                         obs_q[2].cyc - obs_q[1].cyc - 1, GAP);
            end
            tests++;
            if (obs_q[1].cyc - obs_q[0].cyc !== 1) begin
                fails++;
                $display("FAIL b2b_same_pkt: words 0/1 %0d cycles apart, want 1",
                         obs_q[1].cyc - obs_q[0].cyc);
            end
        end
    endtask

    task automatic test_sop_err();
        clear();
        br_mode = 0;
        send_pkt(100, 1, 0, 30);
        drain();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL soperr_count: got %0d words, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if ({obs_q[i].eop, obs_q[i].nsym, obs_q[i].data} !==
                {exp_q[i].eop, exp_q[i].nsym, exp_q[i].data}) begin
                fails++;
                $display("FAIL soperr_word%0d: got eop=%b nsym=%0d data=%h, want eop=%b nsym=%0d data=%h",
                         i, obs_q[i].eop, obs_q[i].nsym, obs_q[i].data,
                         exp_q[i].eop, exp_q[i].nsym, exp_q[i].data);
            end
        end
        tests++;
        if (err_n !== 1) begin
            fails++;
            $display("FAIL soperr_pulse: got %0d err cycles, want 1", err_n);
        end
    endtask

    task automatic test_no_sop();
        int a;
        clear();
        br_mode = 0;
        drive_beat(8'($urandom), 1'b0, 1'b0, a);
        drive_beat(8'($urandom), 1'b0, 1'b1, a);
        st_valid = 1'b0;
        st_eop   = 1'b0;
        repeat (40) @(negedge clk_bus);
        tests++;
        if (err_n !== 2 || obs_q.size() !== 0) begin
            fails++;
            $display("FAIL nosop: got %0d err pulses and %0d words, want 2 and 0",
                     err_n, obs_q.size());
        end
        clear();
        send_pkt(5, 1, 0, -1);
        drain();
        tests++;
        if (obs_q.size() !== 1) begin
            fails++;
            $display("FAIL nosop_follow_count: got %0d words, want 1", obs_q.size());
        end else begin
            tests++;
            if ({obs_q[0].eop, obs_q[0].nsym, obs_q[0].data} !==
                {exp_q[0].eop, exp_q[0].nsym, exp_q[0].data}) begin
                fails++;
                $display("FAIL nosop_follow_word: got eop=%b nsym=%0d data=%h, want eop=%b nsym=%0d data=%h",
                         obs_q[0].eop, obs_q[0].nsym, obs_q[0].data,
                         exp_q[0].eop, exp_q[0].nsym, exp_q[0].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a;
        clear();
        br_mode = 1;
        for (int k = 0; k < 100; k++) drive_beat(8'($urandom), k == 0, 1'b0, a);
        st_valid = 1'b0;
        st_sop   = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk_bus);
        tests++;
        if ({st_ready, bus_en, bus_eop, bus_nsym, bus_data, err_pulse} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got ready=%b en=%b eop=%b nsym=%0d err=%b data!=0:%b, want all 0",
                     st_ready, bus_en, bus_eop, bus_nsym, err_pulse, |bus_data);
        end
        repeat (2) @(negedge clk_bus);
        rst_n   = 1'b1;
        br_mode = 0;
        clear();
        repeat (60) @(negedge clk_bus);
        tests++;
        if (obs_q.size() !== 0) begin
            fails++;
            $display("FAIL rstmid_stray: got %0d words after release, want 0", obs_q.size());
        end
        clear();
        send_pkt(1, 1, 0, -1);
        drain();
        tests++;
        if (obs_q.size() !== 1) begin
            fails++;
            $display("FAIL rstmid_follow_count: got %0d words, want 1", obs_q.size());
        end else begin
            tests++;
            if ({obs_q[0].eop, obs_q[0].nsym, obs_q[0].data} !==
                {exp_q[0].eop, exp_q[0].nsym, exp_q[0].data}) begin
                fails++;
                $display("FAIL rstmid_follow_word: got eop=%b nsym=%0d data=%h, want eop=%b nsym=%0d data=%h",
                         obs_q[0].eop, obs_q[0].nsym, obs_q[0].data,
                         exp_q[0].eop, exp_q[0].nsym, exp_q[0].data);
            end
        end
    endtask

    task automatic test_random();
        clear();
        br_mode = 2;
        for (int p = 0; p < 6; p++) begin
            send_pkt($urandom_range(1, 200), 1, 2, -1);
            @(negedge clk_bus);
        end
        drain();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d words, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if ({obs_q[i].eop, obs_q[i].nsym, obs_q[i].data} !==
                {exp_q[i].eop, exp_q[i].nsym, exp_q[i].data}) begin
                fails++;
                $display("FAIL rand_word%0d: got eop=%b nsym=%0d data=%h, want eop=%b nsym=%0d data=%h",
                         i, obs_q[i].eop, obs_q[i].nsym, obs_q[i].data,
                         exp_q[i].eop, exp_q[i].nsym, exp_q[i].data);
            end
        end
        for (int i = 1; i < obs_q.size(); i++) begin
            if (obs_q[i-1].eop) begin
                tests++;
                if (obs_q[i].cyc - obs_q[i-1].cyc - 1 < GAP) begin
                    fails++;
                    $display("FAIL rand_gap%0d: got %0d idle cycles, want >= %0d",
                             i, obs_q[i].cyc - obs_q[i-1].cyc - 1, GAP);
                end
            end
        end
        tests++;
        if (err_n !== 0) begin
            fails++;
            $display("FAIL rand_err: got %0d err pulses, want 0", err_n);
        end
        br_mode = 0;
    endtask

    initial begin
        test_reset();
        test_p128();
        test_short();
        test_backpressure();
        test_back_to_back();
        test_sop_err();
        test_no_sop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
